// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with delayed chip enable after reset, imem ready
// handshake, flush/branch redirect and a one-entry buffer for branches that resolve during a stall.
module pc_fetch_unit #(
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          STEP         = 4,
    parameter int          STALL_WIDTH  = 6,
    parameter int          ENABLE_DELAY = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STALL_WIDTH-1:0] stop_all,
    input  logic                   imem_ready,
    input  logic                   is_branch_input,
    input  logic [ADDR_WIDTH-1:0]  branch_address_input,
    input  logic                   flush_input,
    input  logic [ADDR_WIDTH-1:0]  new_program_counter_input,
    output logic [ADDR_WIDTH-1:0]  program_counter,
    output logic                   chip_enable,
    output logic                   branch_pending,
    output logic                   pc_misaligned
);

    localparam int                    CNT_W     = (ENABLE_DELAY > 1) ? $clog2(ENABLE_DELAY) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(ENABLE_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC  = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] STEP_INC  = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] STEP_MASK = ADDR_WIDTH'(STEP - 1);

    typedef enum logic {HOLD, RUN} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic [ADDR_WIDTH-1:0]   pend_addr, pend_addr_next;
    logic                    pend_next;
    logic                    ce_next;
    logic                    advance;
    logic                    unused_stall;

    // Only bit 0 stalls fetch; the rest of the vector belongs to later stages.
    assign unused_stall = |stop_all;
    assign advance      = ~stop_all[0] & imem_ready;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pc_next        = program_counter;
        pend_next      = branch_pending;
        pend_addr_next = pend_addr;
        ce_next        = chip_enable;
        case (state)
            HOLD: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_next = RUN;
                    ce_next    = 1'b1;
                    cnt_next   = cnt;
                end
            end
            RUN: begin
                ce_next = 1'b1;
                if (flush_input) begin
                    pc_next   = new_program_counter_input;
                    pend_next = 1'b0;
                end else if (advance && is_branch_input) begin
                    // A fresh branch supersedes anything still buffered.
                    pc_next   = branch_address_input;
                    pend_next = 1'b0;
                end else if (advance && branch_pending) begin
                    pc_next   = pend_addr;
                    pend_next = 1'b0;
                end else if (advance) begin
                    pc_next = program_counter + STEP_INC;
                end else if (is_branch_input) begin
                    pend_addr_next = branch_address_input;
                    pend_next      = 1'b1;
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= HOLD;
            cnt             <= '0;
            chip_enable     <= 1'b0;
            program_counter <= RESET_PC;
            branch_pending  <= 1'b0;
            pend_addr       <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            chip_enable     <= ce_next;
            program_counter <= pc_next;
            branch_pending  <= pend_next;
            pend_addr       <= pend_addr_next;
        end
    end

    assign pc_misaligned = |(program_counter & STEP_MASK);

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the current program-counter register in the MIPS fetch stage.
- Produces the fetch address and the instruction-memory chip enable.
- Adds: a configurable reset vector, a configurable post-reset enable delay, and an instruction-memory ready handshake.
- Adds a pending-branch buffer. A branch resolved while fetch is stalled is held and applied when the stall releases, instead of being dropped.

Parameters:
- ADDR_WIDTH, 32, width of the program counter and of all address inputs.
- RESET_VECTOR, 32'h00000000, PC value held while the chip enable is deasserted. Truncated to ADDR_WIDTH.
- STEP, 4, sequential increment in bytes. Must be a power of two and ≥1.
- STALL_WIDTH, 6, width of stop_all. Only bit 0 (fetch-stage stall) is used.
- ENABLE_DELAY, 1, number of clock cycles after reset deassertion before chip_enable rises. Must be ≥1.

Ports:
- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stop_all  input  STALL_WIDTH  pipeline stall vector; bit 0 = 1 stalls fetch.
- imem_ready  input  1  instruction memory accepted the current address this cycle.
- is_branch_input  input  1  branch/jump taken this cycle.
- branch_address_input  input  ADDR_WIDTH  branch target.
- flush_input  input  1  exception/eret flush.
- new_program_counter_input  input  ADDR_WIDTH  flush target (exception vector or EPC).
- program_counter  output  ADDR_WIDTH  current fetch address (registered).
- chip_enable  output  1  instruction-memory enable (registered).
- branch_pending  output  1  a buffered branch target is waiting (registered).
- pc_misaligned  output  1  combinational; high when program_counter mod STEP ≠ 0.

Behaviour:
- **Reset values.** reset=1 at a rising edge forces state=HOLD, hold counter=0, chip_enable=0, program_counter=RESET_VECTOR, branch_pending=0 and pending address=0. This applies at any time, including mid-stall or with a branch pending.
- **HOLD state.**
  - The counter increments each cycle.
  - When the counter reaches ENABLE_DELAY-1, the next edge enters RUN and sets chip_enable=1.
  - With ENABLE_DELAY=1, chip_enable rises on the first edge after reset deasserts.
  - In HOLD, program_counter stays RESET_VECTOR and all branch/flush inputs are ignored.
- **RUN state.** chip_enable=1. It stays in RUN until reset.
- **Advance condition.** advance = (stop_all[0]==0) && imem_ready.
- **PC update in RUN**, priority high to low, evaluated at each rising edge:
  1. flush_input=1:
     - PC <= new_program_counter_input, regardless of stall or imem_ready.
     - branch_pending <= 0; any concurrent branch is discarded.
  2. advance && is_branch_input:
     - PC <= branch_address_input.
     - branch_pending <= 0, even if an older branch was pending; the newer branch wins.
  3. advance && branch_pending:
     - PC <= pending address.
     - branch_pending <= 0.
  4. advance:
     - PC <= PC + STEP, modulo 2^ADDR_WIDTH.
     - The all-ones region wraps to 0 with no flag.
  5. Not advancing and is_branch_input=1:
     - pending address <= branch_address_input; branch_pending <= 1.
     - PC holds.
     - If a branch is already pending, the new target overwrites it.
  6. Otherwise: PC and the pending state hold.
- **Latency.** One cycle: inputs sampled at edge N appear on program_counter after edge N. No combinational path from inputs to program_counter or chip_enable.
- **Addresses.** Branch and flush addresses are used unmodified; misalignment is reported only via pc_misaligned.
- **Unused stall bits.** stop_all bits above 0 have no effect.

Test Plan:
- **Reset, delay 1.** reset high 3 cycles then low, ENABLE_DELAY=1, RESET_VECTOR=32'hBFC00000 -> chip_enable=0 and PC=BFC00000 through the first post-reset edge. Then chip_enable=1, and PC increments by 4 per cycle with imem_ready=1 (BFC00004, BFC00008…). Repeat with ENABLE_DELAY=3 -> chip_enable rises 3 edges after reset release.
- **Sequential, stall, backpressure.** PC=0x100; stop_all=6'b000001 for 2 cycles -> PC holds 0x100. Release -> 0x104. imem_ready=0 for 1 cycle -> PC holds 0x104.
- **Branch during stall.** PC=0x200, stall asserted, is_branch_input=1 with target 0x400 for one cycle -> branch_pending=1, PC=0x200. Release the stall -> PC=0x400, branch_pending=0. Next cycle -> 0x404.
- **Overwrite and newer branch.** During a stall, branch to 0x500 then branch to 0x600 -> pending=0x600. Then on the advance cycle a branch to 0x700 -> PC=0x700, pending cleared.
- **Flush priority.** With branch_pending=1, stall=1 and is_branch_input=1, assert flush with target 0x80000180 -> PC=0x80000180, branch_pending=0. The next advance gives 0x80000184.
- **Wrap, misalignment, reset mid-op.**
  - PC=0xFFFFFFFC, advance -> 0x00000000.
  - Branch to 0x1002 -> pc_misaligned=1.
  - Assert reset while branch_pending=1 -> next edge: PC=RESET_VECTOR, chip_enable=0, branch_pending=0.
